// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  // Wide enough for the largest access latency (15 cycles).
  localparam int CNT_W = 4;

  // Requester indices: 0 = CPU core, 1 = program loader.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled into one interface.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              m0_req,   m1_req;
  logic              m0_we,    m1_we;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_done,  m1_done;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory view.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to whoever was not served last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // Combinational winner selection.
  always_comb begin
    winner = REQ_CPU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one fixed-latency memory port.
// All outputs are registered from the current state, so each output appears
// one cycle after the state that produces it: the ACCESS state therefore starts
// in the gnt cycle and mem_cs is seen for the following MEM_LAT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              last_q,      last_d;
  logic              sel_q,       sel_d;
  logic              we_q,        we_d;
  logic [1:0]        gnt_q,       gnt_d;
  logic [1:0]        done_q,      done_d;
  logic              mem_cs_q,    mem_cs_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q,    rdata0_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;

  logic [1:0] req_v;
  logic       winner;

  assign req_v = {bus.m1_req, bus.m0_req};

  arb_rr2 u_arb (
    .req    (req_v),
    .last   (last_q),
    .winner (winner)
  );

  // Next-state and next-output logic of the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    gnt_d       = '0;
    done_d      = '0;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          // The address/data registers double as the latch for the whole access.
          sel_d         = winner;
          we_d          = winner ? bus.m1_we    : bus.m0_we;
          mem_addr_d    = winner ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d   = winner ? bus.m1_wdata : bus.m0_wdata;
          gnt_d[winner] = 1'b1;
          cnt_d         = '0;
          state_d       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_cs_d = 1'b1;
        mem_we_d = we_q;
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          last_d  = sel_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // mem_cs is still visible this cycle (last access cycle), so read data is valid now.
        done_d[sel_q] = 1'b1;
        if (!we_q) begin
          if (sel_q) rdata1_d = bus.mem_rdata;
          else       rdata0_d = bus.mem_rdata;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= REQ_LDR;
      sel_q       <= REQ_CPU;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = done_q[0];
  assign bus.m1_done   = done_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected accesses plus scenario tasks.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b15 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1))   dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15))  dut15 (.clk(clk), .rst_n(rst_n), .bus(b15));

  typedef struct {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  typedef struct {
    logic who;
    int   cyc;
  } gnt_t;

  txn_t          exp_q[$];
  gnt_t          gnt_log[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] rd_model [2];
  int            errors   = 0;
  int            checks   = 0;
  int            cyc      = 0;
  int            cs_cnt   = 0;
  int            gnt_cyc  = 0;
  int            done_cnt = 0;

  // Memory model: written on the write strobe, unwritten locations have a fixed pattern.
  bit [DW-1:0] mem     [0:(1<<AW)-1];
  bit          wr_flag [0:(1<<AW)-1];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a == 13'h0005) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      wr_flag[bus.mem_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    bus.mem_rdata <= wr_flag[bus.mem_addr] ? mem[bus.mem_addr] : dflt(bus.mem_addr);
  end

  assign b1.mem_rdata  = b1.mem_addr[7:0]  ^ 8'h5A;
  assign b15.mem_rdata = b15.mem_addr[7:0] ^ 8'h5A;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  // One step: next negedge plus a little, so outputs are stable and the monitor has run.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor on the main DUT.
  task automatic monitor();
    txn_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        checks++;
        if ((bus.m0_gnt && bus.m1_gnt) || (bus.m0_done && bus.m1_done)) begin
          errors++;
          $display("FAIL exclusive: gnt=%b%b done=%b%b required at most one of each",
                   bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done);
        end
        if (bus.m0_gnt || bus.m1_gnt) begin
          gnt_log.push_back('{who: bus.m1_gnt, cyc: cyc});
          gnt_cyc = cyc;
          cs_cnt  = 0;
        end
        if (bus.mem_cs) begin
          cs_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_cs: mem_cs=1 with no transaction expected at cycle %0d", cyc);
          end else if (bus.mem_addr !== exp_q[0].addr || bus.mem_we !== exp_q[0].we ||
                       (exp_q[0].we && bus.mem_wdata !== exp_q[0].wdata)) begin
            errors++;
            $display("FAIL mem_bus: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata,
                     exp_q[0].addr, exp_q[0].we, exp_q[0].wdata);
          end
        end
        if (bus.m0_done || bus.m1_done) begin
          done_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done: unexpected done m0=%b m1=%b", bus.m0_done, bus.m1_done);
          end else begin
            e = exp_q.pop_front();
            if (bus.m1_done !== e.who) begin
              errors++;
              $display("FAIL done_who: m1_done=%b required requester %0d", bus.m1_done, e.who);
            end
            checks++;
            if (cyc - gnt_cyc + 1 != LAT + 2 || cs_cnt != LAT) begin
              errors++;
              $display("FAIL latency: gnt_to_done=%0d cs_cycles=%0d required %0d and %0d",
                       cyc - gnt_cyc + 1, cs_cnt, LAT + 2, LAT);
            end
            if (!e.we) rd_model[e.who] = e.rdata;
            checks++;
            if (bus.m0_rdata !== rd_model[0] || bus.m1_rdata !== rd_model[1]) begin
              errors++;
              $display("FAIL rdata: m0=%h m1=%h required m0=%h m1=%h",
                       bus.m0_rdata, bus.m1_rdata, rd_model[0], rd_model[1]);
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_q.delete();
    gnt_log.delete();
    rd_model[0] = '0;
    rd_model[1] = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: %0d transactions pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single access through one requester: push expectation, request, drop on gnt, wait done.
  task automatic access(input logic who, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    txn_t e;
    logic got;
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = we ? '0 : ref_read(addr);
    if (we) ref_mem[int'(addr)] = wdata;
    exp_q.push_back(e);
    if (who) begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = who ? bus.m1_gnt : bus.m0_gnt;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout: requester %0d got no gnt, required one", who);
    end
    wait_idle(20);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pulses: gnt/done=%b required 0000",
               {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done});
    end
    checks++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: cs=%b we=%b addr=%h wdata=%h required all 0",
               bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.m0_rdata !== 8'h00 || bus.m1_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: m0=%h m1=%h required 00 00", bus.m0_rdata, bus.m1_rdata);
    end
  endtask

  // m0 read at 0x0005: gnt cycle 1, mem_cs cycles 2-3, done cycle 4, data A5.
  task automatic test_single_read();
    logic [2:0] obs;
    logic [2:0] want [5];
    txn_t e;
    want[0] = 3'b100; want[1] = 3'b010; want[2] = 3'b010; want[3] = 3'b001; want[4] = 3'b000;
    do_reset();
    e.who = 1'b0; e.we = 1'b0; e.addr = 13'h0005; e.wdata = '0; e.rdata = 8'hA5;
    exp_q.push_back(e);
    bus.m0_we = 1'b0; bus.m0_addr = 13'h0005; bus.m0_wdata = '0; bus.m0_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) bus.m0_req = 1'b0;
      obs = {bus.m0_gnt, bus.mem_cs, bus.m0_done};
      checks++;
      if (obs !== want[k-1]) begin
        errors++;
        $display("FAIL single_read_c%0d: gnt,cs,done=%b required %b", k, obs, want[k-1]);
      end
    end
    checks++;
    if (bus.m0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL single_read_data: m0_rdata=%h required a5", bus.m0_rdata);
    end
    wait_idle(5);
  endtask

  // m1 write to the top address leaves m1_rdata alone; m0 reads it back.
  task automatic test_write();
    access(1'b1, 1'b0, 13'h0020, '0);
    access(1'b1, 1'b1, 13'h1FFF, 8'h3C);
    checks++;
    if (bus.m1_rdata !== 8'h1C) begin
      errors++;
      $display("FAIL write_keeps_rdata: m1_rdata=%h required 1c", bus.m1_rdata);
    end
    access(1'b0, 1'b0, 13'h1FFF, '0);
    checks++;
    if (bus.m0_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_readback: m0_rdata=%h required 3c", bus.m0_rdata);
    end
  endtask

  // Both requesters held from reset: m0,m1,m0,m1 with gnt every LAT+2 cycles.
  task automatic test_back_to_back();
    txn_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.who = 1'(i % 2); e.we = 1'b0; e.wdata = '0;
      e.addr = e.who ? 13'h0020 : 13'h0010;
      e.rdata = ref_read(e.addr);
      exp_q.push_back(e);
    end
    bus.m0_we = 1'b0; bus.m0_addr = 13'h0010; bus.m0_req = 1'b1;
    bus.m1_we = 1'b0; bus.m1_addr = 13'h0020; bus.m1_req = 1'b1;
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++) tick();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    wait_idle(20);
    checks++;
    if (gnt_log.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: grants=%0d required 4", gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt_log[i].who !== 1'(i % 2)) begin
          errors++;
          $display("FAIL b2b_order%0d: requester=%0d required %0d", i, gnt_log[i].who, i % 2);
        end
        if (i > 0) begin
          checks++;
          if (gnt_log[i].cyc - gnt_log[i-1].cyc != LAT + 2) begin
            errors++;
            $display("FAIL b2b_spacing%0d: spacing=%0d required %0d",
                     i, gnt_log[i].cyc - gnt_log[i-1].cyc, LAT + 2);
          end
        end
      end
    end
  endtask

  // Address and req wiggle after gnt must not disturb the in-flight read.
  task automatic test_mid_change();
    txn_t e;
    logic got;
    int   d0;
    e.who = 1'b0; e.we = 1'b0; e.addr = 13'h0040; e.wdata = '0; e.rdata = ref_read(13'h0040);
    exp_q.push_back(e);
    d0 = done_cnt;
    bus.m0_we = 1'b0; bus.m0_addr = 13'h0040; bus.m0_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = bus.m0_gnt;
    end
    bus.m0_addr = 13'h0999; bus.m0_req = 1'b0;
    tick();
    bus.m0_req = 1'b1;
    tick();
    bus.m0_req = 1'b0;
    tick(6);
    checks++;
    if (!got || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL mid_change: gnt_seen=%b dones=%0d required 1 and 1", got, done_cnt - d0);
    end
    wait_idle(5);
  endtask

  // Reset in the second mem_cs cycle aborts silently and restores the CPU-first tie break.
  task automatic test_reset_mid_access();
    txn_t e;
    logic got;
    do_reset();
    e.who = 1'b0; e.we = 1'b0; e.addr = 13'h0050; e.wdata = '0; e.rdata = ref_read(13'h0050);
    exp_q.push_back(e);
    bus.m0_we = 1'b0; bus.m0_addr = 13'h0050; bus.m0_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = bus.m0_gnt;
    end
    bus.m0_req = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.mem_cs, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: gnt=%b%b done=%b%b cs=%b we=%b addr=%h rdata=%h required all 0",
               bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done, bus.mem_cs, bus.mem_we,
               bus.mem_addr, bus.m0_rdata);
    end
    rst_n = 1'b1;
    exp_q.delete();
    gnt_log.delete();
    rd_model[0] = '0;
    rd_model[1] = '0;
    e.who = 1'b0; e.addr = 13'h0010; e.rdata = ref_read(13'h0010);
    exp_q.push_back(e);
    e.who = 1'b1; e.addr = 13'h0020; e.rdata = ref_read(13'h0020);
    exp_q.push_back(e);
    bus.m0_addr = 13'h0010; bus.m0_req = 1'b1;
    bus.m1_we = 1'b0; bus.m1_addr = 13'h0020; bus.m1_req = 1'b1;
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) tick();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    wait_idle(20);
    checks++;
    if (gnt_log.size() < 1 || gnt_log[0].who !== REQ_CPU) begin
      errors++;
      $display("FAIL post_reset_tie: first grants=%0d first=%0d required CPU first",
               gnt_log.size(), (gnt_log.size() > 0) ? int'(gnt_log[0].who) : -1);
    end
    access(1'b1, 1'b0, 13'h0030, '0);
  endtask

  // Latency extremes on the MEM_LAT=1 and MEM_LAT=15 instances.
  task automatic test_latency_builds();
    int gnt_at;
    int done_at;
    b1.m0_we = 1'b0; b1.m0_addr = 13'h0033; b1.m0_req = 1'b1;
    gnt_at = -1; done_at = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (b1.m0_gnt && gnt_at < 0) begin gnt_at = i; b1.m0_req = 1'b0; end
      if (b1.m0_done && done_at < 0) done_at = i;
    end
    checks++;
    if (gnt_at < 0 || done_at - gnt_at + 1 != 3) begin
      errors++;
      $display("FAIL lat1: gnt=%0d done=%0d required inclusive span 3", gnt_at, done_at);
    end
    checks++;
    if (b1.m0_rdata !== 8'h69) begin
      errors++;
      $display("FAIL lat1_data: m0_rdata=%h required 69", b1.m0_rdata);
    end
    b15.m0_we = 1'b0; b15.m0_addr = 13'h0077; b15.m0_req = 1'b1;
    gnt_at = -1; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b15.m0_gnt && gnt_at < 0) begin gnt_at = i; b15.m0_req = 1'b0; end
      if (b15.m0_done && done_at < 0) done_at = i;
    end
    checks++;
    if (gnt_at < 0 || done_at - gnt_at + 1 != 17) begin
      errors++;
      $display("FAIL lat15: gnt=%0d done=%0d required inclusive span 17", gnt_at, done_at);
    end
    checks++;
    if (b15.m0_rdata !== 8'h2D) begin
      errors++;
      $display("FAIL lat15_data: m0_rdata=%h required 2d", b15.m0_rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    b1.m0_req  = 1'b0; b1.m0_we  = 1'b0; b1.m0_addr  = '0; b1.m0_wdata  = '0;
    b1.m1_req  = 1'b0; b1.m1_we  = 1'b0; b1.m1_addr  = '0; b1.m1_wdata  = '0;
    b15.m0_req = 1'b0; b15.m0_we = 1'b0; b15.m0_addr = '0; b15.m0_wdata = '0;
    b15.m1_req = 1'b0; b15.m1_we = 1'b0; b15.m1_addr = '0; b15.m1_wdata = '0;
    rd_model[0] = '0;
    rd_model[1] = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_mid_change();
    test_reset_mid_access();
    test_latency_builds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 13, memory address width.
REQ-002 SHALL have parameter DATA_W, 8, memory data width.
REQ-003 SHALL have parameter MEM_LAT, 2, memory read latency in cycles from first mem_cs cycle to mem_rdata valid; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports m0_req / m1_req  input  1  access request, level, requester 0 = CPU core, requester 1 = program loader.
REQ-007 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr / m1_addr  input  ADDR_W  access address.
REQ-009 SHALL have ports m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse, request accepted and latched.
REQ-011 SHALL have ports m0_done / m1_done  output  1  one-cycle pulse, access complete.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  DATA_W  registered read data, valid from done, held until that requester's next read completes.
REQ-013 SHALL have ports mem_cs, mem_we  output  1  memory select and write strobe.
REQ-014 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other states reachable.
REQ-016 IDLE: if neither req high, stay; else select winner, latch its we/addr/wdata, pulse its gnt, go ACCESS next cycle.
REQ-017 Arbitration SHALL be 2-way round-robin: single request wins outright; both high -> requester not served last wins; last-served pointer updates on entry to DONE.
REQ-018 ACCESS SHALL last exactly MEM_LAT cycles with mem_cs=1, mem_addr/mem_wdata/mem_we driven from latched values and constant throughout.
REQ-019 Read: mem_rdata sampled on last ACCESS cycle into winner's rdata register; other requester's rdata unchanged.
REQ-020 Write: rdata registers unchanged; mem_we=1 for every ACCESS cycle.
REQ-021 DONE: winner's done=1 for one cycle, mem_cs=0, then IDLE.
REQ-022 Transaction latency SHALL be MEM_LAT+2 cycles from gnt cycle to done cycle inclusive; back-to-back throughput one access per MEM_LAT+2 cycles.
REQ-023 req changes after gnt SHALL NOT affect the transaction in flight; req still high in IDLE is a new request.
REQ-024 gnt and done SHALL never be high for both requesters in one cycle; mem_cs=0 outside ACCESS.
REQ-025 Outputs mem_* and gnt/done SHALL be registered, not combinational from req.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, all gnt/done=0, m0_rdata=m1_rdata=0, last-served pointer=1 (CPU wins first tie).
REQ-027 Reset during ACCESS SHALL abort the access with no done pulse; first request after reset release sees arbitration from IDLE.

Structure
REQ-028 State encoding, ADDR_W/DATA_W defaults and requester index constants SHALL live in shared package mem_arb_pkg.
REQ-029 Round-robin pick SHALL be sub-module arb_rr2 (inputs req[1:0], last; output winner); counter and FSM stay in mem_arbiter.

Verification
REQ-030 Reset then m0 read addr 0x0005, mem returns 0xA5 -> m0_gnt cycle 1, mem_cs cycles 2-3, m0_done cycle 4, m0_rdata=0xA5.
REQ-031 m0 and m1 req high same cycle after reset, both held -> order m0,m1,m0,m1, gnt spacing 4 cycles (MEM_LAT=2).
REQ-032 m1 write 0x1FFF data 0x3C -> mem_we=mem_cs=1 two cycles, mem_addr=0x1FFF, mem_wdata=0x3C, m1_done, m1_rdata unchanged.
REQ-033 m0 read in ACCESS, m0_addr/m0_req change mid-access -> mem_addr stays latched value, single done.
REQ-034 rst_n low in second ACCESS cycle -> next cycle all outputs 0, no done; m1 request then granted first only if m0 idle.
REQ-035 MEM_LAT=1 and MEM_LAT=15 builds -> done exactly 3 and 17 cycles after gnt respectively.
